key_freq_ctrl: RTL

Multi-channel key-controlled blink-frequency generator with multiplexed 7-segment readout. Each of `CH` LED channels toggles at its own programmable half-period, counted in ticks of an internal slow time base. Three debounced keys select a channel and raise or lower its frequency, with auto-repeat while a key is held. The selected channel's toggle rate is converted by a sequential divider and a double-dabble unit into BCD digits, which a scan counter drives to the board's existing segment decoder and digit-select logic.

---
 rtl/key_freq_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_freq_ctrl.sv
// key_freq_ctrl: per-channel LED blinkers with key-adjusted half-periods
// and a multiplexed BCD readout of the selected channel's toggle rate.
module key_freq_ctrl #(
    parameter int F_CLK       = 50000000,
    parameter int F_TICK      = 1000,
    parameter int CH          = 4,
    parameter int DIGITS      = 4,
    parameter int PERIOD_MIN  = 100,
    parameter int PERIOD_MAX  = 1000,
    parameter int PERIOD_STEP = 100,
    parameter int PERIOD_INIT = 1000,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_up,
    input  logic                    key_dn,
    input  logic                    key_sel,
    output logic [CH-1:0]           led,
    output logic [$clog2(CH)-1:0]   ch_sel,
    output logic [3:0]              dig_bcd,
    output logic                    dig_dp,
    output logic [DIGITS-1:0]       dig_en,
    output logic                    busy
);

    localparam int TDIV = F_CLK / F_TICK;
    localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam int PW   = $clog2(PERIOD_MAX + 1);
    localparam int CW   = $clog2(CH);
    localparam int DW   = $clog2(DIGITS);
    localparam int RPW  = $clog2(REPEAT_DLY + 1);
    localparam int W    = $clog2(100 * F_TICK / PERIOD_MIN + 1);
    localparam int SW   = $clog2(W + 1);
    localparam int BW   = 4 * DIGITS;

    localparam logic [31:0]  NUM_V  = 32'(100 * F_TICK);
    localparam logic [31:0]  NUM_HI = NUM_V >> W;
    localparam logic [W-1:0] NUM_LO = NUM_V[W-1:0];
    localparam logic [31:0]  VMAX   = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_BCD, S_LOAD} state_t;

    logic [TW-1:0]  tcnt;
    logic           tick;
    logic           up_q, dn_q, sel_q;
    logic           both, hold, rpt_fire;
    logic           up_ev, dn_ev, sel_ev;
    logic [RPW-1:0] rpt_cnt;
    logic [PW-1:0]  period [CH];
    logic [PW-1:0]  cnt [CH];
    logic [PW-1:0]  cur, p_new;
    logic           p_chg;
    logic           pending;
    state_t         state, state_n;
    logic [SW-1:0]  step;
    logic [PW-1:0]  divisor;
    logic [PW-1:0]  rem;
    logic [PW:0]    rem_sh;
    logic           ge;
    logic [W-1:0]   q, q_next;
    logic [BW-1:0]  bcd, bcd_adj;
    logic           sat;
    logic [3:0]     disp [DIGITS];
    logic [DW-1:0]  ptr;

    assign tick = (tcnt == TW'(TDIV - 1));

    // Free-running time base; tick marks each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    // Previous key levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {up_q, dn_q, sel_q} <= '0;
        else     {up_q, dn_q, sel_q} <= {key_up, key_dn, key_sel};
    end

    assign both     = key_up & key_dn;
    assign hold     = key_up ^ key_dn;
    assign rpt_fire = hold & tick & (rpt_cnt == RPW'(REPEAT_DLY - 1));
    assign up_ev    = ~both & key_up & (~up_q | rpt_fire);
    assign dn_ev    = ~both & key_dn & (~dn_q | rpt_fire);
    assign sel_ev   = key_sel & ~sel_q;

    // Hold timer: first repeat after REPEAT_DLY ticks, then every REPEAT_RATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rpt_cnt <= '0;
        else if (!hold || (key_up & ~up_q) || (key_dn & ~dn_q))
            rpt_cnt <= '0;
        else if (rpt_fire)
            rpt_cnt <= RPW'(REPEAT_DLY - REPEAT_RATE);
        else if (tick)
            rpt_cnt <= rpt_cnt + 1'b1;
    end

    // Saturating period adjustment for the selected channel.
    always_comb begin
        cur   = period[ch_sel];
        p_new = cur;
        if (up_ev)
            p_new = (cur >= PW'(PERIOD_MIN + PERIOD_STEP)) ?
                    cur - PW'(PERIOD_STEP) : PW'(PERIOD_MIN);
        else if (dn_ev)
            p_new = (32'(cur) + 32'(PERIOD_STEP) <= 32'(PERIOD_MAX)) ?
                    cur + PW'(PERIOD_STEP) : PW'(PERIOD_MAX);
    end

    assign p_chg = (p_new != cur);

    // Channel blinkers; a period change restarts that channel's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
            for (int i = 0; i < CH; i++) begin
                period[i] <= PW'(PERIOD_INIT);
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (p_chg && ch_sel == CW'(i)) begin
                    period[i] <= p_new;
                    cnt[i]    <= '0;
                end else if (tick) begin
                    if (cnt[i] == period[i] - 1'b1) begin
                        cnt[i] <= '0;
                        led[i] <= ~led[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Channel selection, wrapping at the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ch_sel <= '0;
        else if (sel_ev)
            ch_sel <= (ch_sel == CW'(CH - 1)) ? '0 : ch_sel + 1'b1;
    end

    // Conversion request; a trigger while busy forces one rerun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= 1'b1;
        else     pending <= sel_ev | p_chg | (pending & (state != S_IDLE));
    end

    // Conversion state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Conversion next-state and busy flag.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        unique case (state)
            S_IDLE: if (pending) state_n = S_DIV;
            S_DIV: begin
                busy = 1'b1;
                if (step == SW'(W - 1)) state_n = S_BCD;
            end
            S_BCD: begin
                busy = 1'b1;
                if (step == SW'(W - 1)) state_n = S_LOAD;
            end
            S_LOAD:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign rem_sh = {rem, q[W-1]};
    assign ge     = (rem_sh >= {1'b0, divisor});
    assign q_next = {q[W-2:0], ge};

    // Add-3 correction of every BCD digit before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++)
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end

    // Divider, double-dabble and display load datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step    <= '0;
            divisor <= '0;
            rem     <= '0;
            q       <= '0;
            bcd     <= '0;
            sat     <= 1'b0;
            for (int k = 0; k < DIGITS; k++) disp[k] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pending) begin
                        divisor <= period[ch_sel];
                        rem     <= NUM_HI[PW-1:0];
                        q       <= NUM_LO;
                        step    <= '0;
                    end
                end
                S_DIV: begin
                    rem  <= ge ? PW'(rem_sh - {1'b0, divisor}) : rem_sh[PW-1:0];
                    q    <= q_next;
                    step <= (step == SW'(W - 1)) ? '0 : step + 1'b1;
                    if (step == SW'(W - 1)) begin
                        bcd <= '0;
                        sat <= (32'(q_next) > VMAX);
                    end
                end
                S_BCD: begin
                    bcd  <= {bcd_adj[BW-2:0], q[W-1]};
                    q    <= {q[W-2:0], 1'b0};
                    step <= (step == SW'(W - 1)) ? '0 : step + 1'b1;
                end
                S_LOAD: begin
                    for (int k = 0; k < DIGITS; k++)
                        disp[k] <= sat ? 4'd9 : bcd[4*(DIGITS-1-k) +: 4];
                end
                default: ;
            endcase
        end
    end

    // Digit scan pointer, one digit per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (tick)
            ptr <= (ptr == DW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
    end

    // Active digit drive.
    always_comb begin
        dig_en      = '0;
        dig_en[ptr] = 1'b1;
        dig_bcd     = disp[ptr];
        dig_dp      = (ptr == DW'(DIGITS - 3));
    end

endmodule
